// File: rtl/chunked_add_sequencer.sv
// Multi-cycle wide adder: streams CHUNK-bit slices through one carry_select_adder.
// Optional subtract mode is enabled by defining CHUNKED_ADD_SUB_EN.

module carry_select_adder #(
    parameter int WIDTH      = 8,
    parameter int BLOCK_SIZE = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NB = WIDTH / BLOCK_SIZE;

    logic [NB:0] c;

    assign c[0] = cin;

    for (genvar g = 0; g < NB; g++) begin : g_blk
        logic [BLOCK_SIZE:0] s0;
        logic [BLOCK_SIZE:0] s1;

        // Both carry-in cases are precomputed; the ripple only drives the mux.
        assign s0 = {1'b0, a[g*BLOCK_SIZE +: BLOCK_SIZE]}
                  + {1'b0, b[g*BLOCK_SIZE +: BLOCK_SIZE]};
        assign s1 = {1'b0, a[g*BLOCK_SIZE +: BLOCK_SIZE]}
                  + {1'b0, b[g*BLOCK_SIZE +: BLOCK_SIZE]}
                  + (BLOCK_SIZE+1)'(1);

        assign sum[g*BLOCK_SIZE +: BLOCK_SIZE] =
            c[g] ? s1[BLOCK_SIZE-1:0] : s0[BLOCK_SIZE-1:0];
        assign c[g+1] = c[g] ? s1[BLOCK_SIZE] : s0[BLOCK_SIZE];
    end

    assign cout = c[NB];
endmodule

module chunked_add_sequencer #(
    parameter int OP_WIDTH   = 32,
    parameter int CHUNK      = 8,
    parameter int BLOCK_SIZE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_WIDTH-1:0] a,
    input  logic [OP_WIDTH-1:0] b,
`ifdef CHUNKED_ADD_SUB_EN
    input  logic                op_sub,
`endif
    input  logic                cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OP_WIDTH-1:0] sum,
    output logic                cout
);
    localparam int NCHUNK = OP_WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CW-1:0]       cnt_q;
    logic [OP_WIDTH-1:0] a_q;
    logic [OP_WIDTH-1:0] b_q;
    logic                carry_q;
    logic [OP_WIDTH-1:0] sum_q;
    logic                cout_q;

    logic [31:0]         base;
    logic [CHUNK-1:0]    add_sum;
    logic                add_cout;
    logic                accept;
    logic                last;

    assign base   = 32'(cnt_q) * 32'(CHUNK);
    assign accept = (state_q == IDLE) && in_valid;
    assign last   = (cnt_q == CW'(NCHUNK-1));

    carry_select_adder #(
        .WIDTH     (CHUNK),
        .BLOCK_SIZE(BLOCK_SIZE)
    ) u_csa (
        .a   (a_q[base +: CHUNK]),
        .b   (b_q[base +: CHUNK]),
        .cin (carry_q),
        .sum (add_sum),
        .cout(add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            cnt_q <= '0;
            a_q   <= a;
`ifdef CHUNKED_ADD_SUB_EN
            // Subtract is a + ~b + 1; cin has no meaning there.
            b_q     <= op_sub ? ~b : b;
            carry_q <= op_sub | cin;
`else
            b_q     <= b;
            carry_q <= cin;
`endif
        end else if (state_q == RUN) begin
            sum_q[base +: CHUNK] <= add_sum;
            carry_q              <= add_cout;
            if (last) begin
                cout_q <= add_cout;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Directed bench for chunked_add_sequencer (OP_WIDTH=32, CHUNK=8).
// Subtract vectors run when CHUNKED_ADD_SUB_EN is defined.

module tb_chunked_add_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
`ifdef CHUNKED_ADD_SUB_EN
    logic        op_sub;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    chunked_add_sequencer #(
        .OP_WIDTH  (32),
        .CHUNK     (8),
        .BLOCK_SIZE(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
`ifdef CHUNKED_ADD_SUB_EN
        .op_sub   (op_sub),
`endif
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag,
                         input logic [31:0] va,
                         input logic [31:0] vb,
                         input logic vcin,
                         input logic [31:0] esum,
                         input logic ecout,
                         output int acc_cyc);
        int lat;
        chk({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        a        = va;
        b        = vb;
        cin      = vcin;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        acc_cyc  = cyc;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            chk({tag, "_in_ready_run"}, 64'(in_ready), 64'd0);
            step();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd4);
        chk({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
        chk({tag, "_sum"}, 64'(sum), 64'(esum));
        chk({tag, "_cout"}, 64'(cout), 64'(ecout));
        step();
        chk({tag, "_out_valid_after"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int t0;
        int t1;
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
`ifdef CHUNKED_ADD_SUB_EN
        op_sub    = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);

        do_op("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0,
              32'h0000_0000, 1'b1, t0);

        do_op("mix", 32'h1234_5678, 32'h8765_4321, 1'b1,
              32'h9999_999A, 1'b0, t0);
        do_op("msb", 32'h8000_0000, 32'h8000_0000, 1'b0,
              32'h0000_0000, 1'b1, t1);
        chk("issue_interval", 64'(t1 - t0), 64'd6);

        // Backpressure with a competing offer held on the input.
        a         = 32'h0000_0001;
        b         = 32'h0000_0002;
        cin       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("bp_latency", 64'(lat), 64'd4);
        a        = 32'hDEAD_BEEF;
        b        = 32'h1111_1111;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_sum", 64'(sum), 64'h3);
            chk("bp_cout", 64'(cout), 64'd0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        do_op("after_bp", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1,
              32'h0000_0000, 1'b1, t0);

        // Abort mid-operation after two slices.
        a        = 32'hFFFF_FFFF;
        b        = 32'hFFFF_FFFF;
        cin      = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_sum", 64'(sum), 64'd0);
        chk("abort_cout", 64'(cout), 64'd0);
        do_op("post_abort", 32'h0000_00FF, 32'h0000_0001, 1'b0,
              32'h0000_0100, 1'b0, t0);

`ifdef CHUNKED_ADD_SUB_EN
        op_sub = 1'b1;
        do_op("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b0,
              32'hFFFF_FFFE, 1'b0, t0);
        do_op("sub_pos", 32'h0000_0007, 32'h0000_0005, 1'b0,
              32'h0000_0002, 1'b1, t0);
        op_sub = 1'b0;
        do_op("add_again", 32'h0000_0007, 32'h0000_0005, 1'b1,
              32'h0000_000D, 1'b0, t0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
